// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset datapath: one shared ALU, internal control FSM, req/ready memory ports.
// Optional performance counters are built only when MULTICYCLE_PERF_EN is defined.
//
// state  | meaning
// FETCH  | imem_req held with imem_addr=PC until imem_ready; IR<=rdata, PC<=PC+1
// DECODE | A/B read from register file, immediate extended; illegal encodings halt
// EXEC   | ALU op, address calc, or branch/jump resolution
// MEM    | dmem_req held until dmem_ready; lw latches MDR
// WB     | register file write (rd for R-type, rt otherwise)
// HALT   | absorbing until reset
module multicycle_datapath #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [2:0]        state,
    output logic              halted,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                halted_q, halted_d;
    logic [DATA_W-1:0]   rf_q [32];

    logic [5:0]          op, fn;
    logic [4:0]          rs, rt, rd, shamt;
    logic                legal;
    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   alu_res;
    logic [ADDR_W-1:0]   br_target, j_target;
    logic                wb_en;
    logic [4:0]          wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                retire;
    logic                imem_req_c, dmem_req_c, dmem_we_c;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign fn    = ir_q[5:0];

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Logical immediates are zero-extended; everything else sign-extends.
    always_comb begin
        if (op == OP_ANDI || op == OP_ORI) begin
            imm_ext = {{(DATA_W-16){1'b0}}, ir_q[15:0]};
        end else begin
            imm_ext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
        end
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  alu_res = a_q + b_q;
                    FN_SUB:  alu_res = a_q - b_q;
                    FN_AND:  alu_res = a_q & b_q;
                    FN_OR:   alu_res = a_q | b_q;
                    FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                    FN_SLL:  alu_res = b_q << shamt;
                    FN_SRL:  alu_res = b_q >> shamt;
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm_q;
            OP_ANDI:               alu_res = a_q & imm_q;
            OP_ORI:                alu_res = a_q | imm_q;
            default:               alu_res = '0;
        endcase
    end

    // PC has already been incremented by the time a branch resolves.
    assign br_target = pc_q + {{(ADDR_W-16){ir_q[15]}}, ir_q[15:0]};
    assign j_target  = {pc_q[ADDR_W-1:26], ir_q[25:0]};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        halted_d   = halted_q;
        wb_en      = 1'b0;
        wb_addr    = rt;
        wb_data    = alu_q;
        retire     = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rf_q[rs];
                b_d   = rf_q[rt];
                imm_d = imm_ext;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end
            end
            S_EXEC: begin
                alu_d = alu_res;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = br_target;
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_BNE: begin
                        if (a_q != b_q) pc_d = br_target;
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_J: begin
                        pc_d    = j_target;
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (op == OP_SW);
                if (dmem_ready) begin
                    if (op == OP_SW) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                wb_addr = (op == OP_RTYPE) ? rd : rt;
                wb_data = (op == OP_LW) ? mdr_q : alu_q;
                wb_en   = (wb_addr != 5'd0);
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT: halted_d = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            halted_q <= halted_d;
        end
    end

    // r0 is never written, so it reads zero without a special read path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wb_en) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Requests drop combinationally with reset so an in-flight access is abandoned at once.
    assign imem_req   = imem_req_c & ~reset;
    assign dmem_req   = dmem_req_c & ~reset;
    assign dmem_we    = dmem_we_c & ~reset;
    assign imem_addr  = pc_q;
    assign dmem_wdata = b_q;
    assign state      = state_q;
    assign halted     = halted_q;

    generate
        if (ADDR_W <= DATA_W) begin : g_addr_trunc
            assign dmem_addr = alu_q[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign dmem_addr = {{(ADDR_W-DATA_W){1'b0}}, alu_q};
        end
    endgenerate

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] ret_q, ret_d;

    assign cyc_d = cyc_q + 32'd1;
    assign ret_d = retire ? ret_q + 32'd1 : ret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign perf_cycles  = cyc_q;
    assign perf_retired = ret_q;
`else
    logic perf_unused;
    assign perf_unused  = retire;
    assign perf_cycles  = '0;
    assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed programs plus random instruction streams,
// checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_datapath;

    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_BR  = 3;
    localparam int K_ILL = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] perf_cycles;
    logic [31:0] perf_retired;

    int checks = 0;
    int failures = 0;

    logic [31:0] regs_m [32];
    logic [31:0] pc_m;
    logic [31:0] imem_m [256];
    logic [31:0] dmem_m [logic [31:0]];

    multicycle_datapath #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .RESET_PC(32'h10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ready  (dmem_ready),
        .state       (state),
        .halted      (halted),
        .perf_cycles (perf_cycles),
        .perf_retired(perf_retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic void wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) regs_m[r] = v;
    endfunction

    // Architectural effect of one instruction; reports what the bus should show.
    task automatic model_exec(input logic [31:0] ins, output int kind,
                              output logic [31:0] ma, output logic [31:0] mw,
                              output logic [31:0] md);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] a, b, se, ze;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
        a  = regs_m[rs]; b = regs_m[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        kind = K_ALU; ma = 32'h0; mw = 32'h0; md = 32'h0;
        pc_m = pc_m + 32'd1;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20:   wr(rd, a + b);
                    6'h22:   wr(rd, a - b);
                    6'h24:   wr(rd, a & b);
                    6'h25:   wr(rd, a | b);
                    6'h2A:   wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    6'h00:   wr(rd, b << sh);
                    6'h02:   wr(rd, b >> sh);
                    default: kind = K_ILL;
                endcase
            end
            6'h08: wr(rt, a + se);
            6'h0C: wr(rt, a & ze);
            6'h0D: wr(rt, a | ze);
            6'h23: begin
                kind = K_LW;
                ma = a + se;
                if (!dmem_m.exists(ma)) dmem_m[ma] = $urandom;
                md = dmem_m[ma];
                wr(rt, md);
            end
            6'h2B: begin
                kind = K_SW;
                ma = a + se;
                mw = b;
                dmem_m[ma] = b;
            end
            6'h04: begin
                kind = K_BR;
                if (a == b) pc_m = pc_m + se;
            end
            6'h05: begin
                kind = K_BR;
                if (a != b) pc_m = pc_m + se;
            end
            6'h02: begin
                kind = K_BR;
                pc_m = {pc_m[31:26], ins[25:0]};
            end
            default: kind = K_ILL;
        endcase
    endtask

    function automatic logic [31:0] rand_ins();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        int          k;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sh  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        k   = $urandom_range(0, 13);
        case (k)
            0:       return r_ins(6'h20, rs, rt, rd, 5'd0);
            1:       return r_ins(6'h22, rs, rt, rd, 5'd0);
            2:       return r_ins(6'h24, rs, rt, rd, 5'd0);
            3:       return r_ins(6'h25, rs, rt, rd, 5'd0);
            4:       return r_ins(6'h2A, rs, rt, rd, 5'd0);
            5:       return r_ins(6'h00, rs, rt, rd, sh);
            6:       return r_ins(6'h02, rs, rt, rd, sh);
            7:       return i_ins(6'h08, rs, rt, imm);
            8:       return i_ins(6'h0C, rs, rt, imm);
            9:       return i_ins(6'h0D, rs, rt, imm);
            10:      return i_ins(6'h23, rs, rt, imm);
            11:      return i_ins(6'h2B, rs, rt, imm);
            12:      return i_ins(6'h04, rs, rt, imm);
            default: return i_ins(6'h05, rs, rt, imm);
        endcase
    endfunction

    // Runs one instruction from pc_m with iw fetch wait cycles and dw data wait cycles.
    // Entered and left just after a falling edge, in the instruction's first fetch cycle.
    task automatic run_instr(input int iw, input int dw);
        logic [31:0] ins, pc0, ma, mw, md;
        int          kind, mem_last;
        int          exp_st[$];
        pc0 = pc_m;
        ins = imem_m[pc0[7:0]];
        model_exec(ins, kind, ma, mw, md);
        for (int i = 0; i <= iw; i++) exp_st.push_back(0);
        exp_st.push_back(1);
        if (kind == K_ILL) begin
            repeat (4) exp_st.push_back(5);
        end else begin
            exp_st.push_back(2);
            if (kind == K_LW || kind == K_SW) repeat (dw + 1) exp_st.push_back(3);
            if (kind == K_ALU || kind == K_LW) exp_st.push_back(4);
        end
        mem_last = iw + 3 + dw;
        for (int c = 0; c < exp_st.size(); c++) begin
            chk("state", 64'(state), 64'(exp_st[c]));
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            imem_rdata = $urandom;
            dmem_rdata = $urandom;
            if (exp_st[c] == 0) begin
                chk("fetch_req", 64'({imem_req, dmem_req}), 64'd2);
                chk("imem_addr", 64'(imem_addr), 64'(pc0));
                chk("halted_low", 64'(halted), 64'd0);
                if (c == iw) begin
                    imem_ready = 1'b1;
                    imem_rdata = ins;
                end
            end else if (exp_st[c] == 3) begin
                chk("mem_req", 64'({imem_req, dmem_req}), 64'd1);
                chk("dmem_we", 64'(dmem_we), 64'(kind == K_SW));
                chk("dmem_addr", 64'(dmem_addr), 64'(ma));
                if (kind == K_SW) chk("dmem_wdata", 64'(dmem_wdata), 64'(mw));
                if (c == mem_last) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = md;
                end
            end else begin
                chk("idle_req", 64'({imem_req, dmem_req}), 64'd0);
                if (exp_st[c] == 5) chk("halted_high", 64'(halted), 64'd1);
            end
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
        pc_m = 32'h10;
        #1;
        chk("rst_perf_cycles", 64'(perf_cycles), 64'd0);
        chk("rst_perf_retired", 64'(perf_retired), 64'd0);
    endtask

    initial begin
        logic [31:0] c0, r0;
        logic [31:0] exp_dc, exp_dr;
        int          n;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        imem_rdata = 32'h0;
        dmem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) imem_m[i] = 32'h0;
`ifdef MULTICYCLE_PERF_EN
        exp_dc = 32'd21;
        exp_dr = 32'd5;
`else
        exp_dc = 32'd0;
        exp_dr = 32'd0;
`endif
        #1;
        do_reset();

        imem_m[8'h10] = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
        imem_m[8'h11] = i_ins(6'h08, 5'd0, 5'd1, 16'd3);
        imem_m[8'h12] = i_ins(6'h08, 5'd0, 5'd2, 16'hFFFF);
        imem_m[8'h13] = r_ins(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        imem_m[8'h14] = i_ins(6'h2B, 5'd0, 5'd3, 16'd4);
        imem_m[8'h15] = i_ins(6'h23, 5'd0, 5'd4, 16'd4);
        imem_m[8'h16] = i_ins(6'h2B, 5'd0, 5'd4, 16'd8);
        imem_m[8'h17] = i_ins(6'h2B, 5'd0, 5'd2, 16'd12);
        imem_m[8'h18] = i_ins(6'h23, 5'd0, 5'd6, 16'd4);
        imem_m[8'h19] = i_ins(6'h2B, 5'd0, 5'd6, 16'd16);
        imem_m[8'h1A] = {6'h02, 26'd8};
        imem_m[8'h08] = i_ins(6'h04, 5'd0, 5'd0, 16'hFFFF);

        run_instr(0, 0);
        c0 = perf_cycles;
        r0 = perf_retired;
        repeat (5) run_instr(0, 0);
        chk("perf_cycles_delta", 64'(perf_cycles - c0), 64'(exp_dc));
        chk("perf_retired_delta", 64'(perf_retired - r0), 64'(exp_dr));
        run_instr(0, 0);
        run_instr(0, 0);
        run_instr(3, 2);
        run_instr(1, 3);
        run_instr(0, 0);
        repeat (3) run_instr(0, 0);
        imem_m[8'h08] = i_ins(6'h05, 5'd0, 5'd0, 16'd5);
        run_instr(0, 0);

        for (int i = 0; i < 256; i++) imem_m[i] = rand_ins();
        repeat (80) run_instr($urandom_range(0, 2), $urandom_range(0, 2));
        for (int k = 1; k < 8; k++) begin
            imem_m[pc_m[7:0]] = i_ins(6'h2B, 5'd0, 5'(k), 16'(k * 4));
            run_instr(0, 1);
        end

        imem_m[pc_m[7:0]] = 32'hFC00_0000;
        run_instr(1, 0);

        do_reset();
        imem_m[8'h10] = i_ins(6'h08, 5'd0, 5'd5, 16'd7);
        imem_m[8'h11] = i_ins(6'h2B, 5'd0, 5'd5, 16'd12);
        run_instr(0, 0);
        imem_ready = 1'b1;
        imem_rdata = imem_m[8'h11];
        @(posedge clk);
        @(negedge clk);
        #1;
        imem_ready = 1'b0;
        n = 0;
        while (!dmem_req && n < 8) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            n++;
        end
        chk("mid_mem_req", 64'(dmem_req), 64'd1);
        #1;
        do_reset();
        imem_m[8'h10] = i_ins(6'h2B, 5'd0, 5'd5, 16'd0);
        run_instr(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
